dmx_break_mab_validator: RTL and testbench

Next-generation DMX512 reset-sequence detector. It measures both the BREAK (line low) and the Mark-After-Break (MAB, line high) against separate parametrised windows, and applies a glitch filter to the line first. It emits a one-cycle frame_start on the start bit of slot 0, latches the measured widths, and reports timing errors, including stuck-low detection before the line releases. It sits between the DMX receive pin and the UART/slot decoder.

---
 rtl/dmx_break_mab_validator_if.sv | 28 ++
 rtl/dmx_break_mab_validator.sv | 173 +++++++++++++++++
 tb/tb_dmx_break_mab_validator.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx_break_mab_validator_if.sv
// Bundle between the DMX receive pin side and the slot decoder for the BREAK/MAB validator.
// Inputs are levels sampled every clock; all outputs are strobes or levels from registers (no valid/ready handshake).
interface dmx_break_mab_validator_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             signal_in;
  logic             frame_start;
  logic [CNT_W-1:0] break_width;
  logic [CNT_W-1:0] mab_width;
  logic             err_long_break;
  logic             err_short_mab;
  logic             err_long_mab;
  logic             line_stuck;
  logic [1:0]       state_dbg;

  modport master (
    output enable, signal_in,
    input  frame_start, break_width, mab_width, err_long_break,
    input  err_short_mab, err_long_mab, line_stuck, state_dbg
  );

  modport slave (
    input  enable, signal_in,
    output frame_start, break_width, mab_width, err_long_break,
    output err_short_mab, err_long_mab, line_stuck, state_dbg
  );
endinterface

// File: rtl/dmx_break_mab_validator.sv
// DMX512 reset-sequence detector: synchronises and glitch-filters the line, then times
// BREAK and MAB against their windows and flags frame start or timing errors.
module dmx_break_mab_validator #(
  parameter int unsigned CLK_FREQ      = 20_000_000,
  parameter int unsigned MIN_BREAK_US  = 88,
  parameter int unsigned MAX_BREAK_MS  = 1000,
  parameter int unsigned MIN_MAB_US    = 8,
  parameter int unsigned MAX_MAB_MS    = 1000,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int          CNT_W         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  dmx_break_mab_validator_if.slave      bus
);

  localparam longint unsigned MIN_BREAK_L = (longint'(CLK_FREQ) / 1_000_000) * MIN_BREAK_US;
  localparam longint unsigned MAX_BREAK_L = (longint'(CLK_FREQ) / 1_000) * MAX_BREAK_MS;
  localparam longint unsigned MIN_MAB_L   = (longint'(CLK_FREQ) / 1_000_000) * MIN_MAB_US;
  localparam longint unsigned MAX_MAB_L   = (longint'(CLK_FREQ) / 1_000) * MAX_MAB_MS;

  localparam logic [CNT_W-1:0] MIN_BREAK_CYC = CNT_W'(MIN_BREAK_L);
  localparam logic [CNT_W-1:0] BRK_SAT       = CNT_W'(MAX_BREAK_L + 1);
  localparam logic [CNT_W-1:0] MIN_MAB_CYC   = CNT_W'(MIN_MAB_L);
  localparam logic [CNT_W-1:0] MAB_SAT       = CNT_W'(MAX_MAB_L + 1);

  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAB   = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  logic             sync1, sync2, filt, filt_d;
  logic [GW-1:0]    gcnt;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] break_hold, break_hold_n;
  logic [CNT_W-1:0] break_w_q, break_w_n, mab_w_q, mab_w_n;
  logic             fs_q, fs_n, elb_q, elb_n, esm_q, esm_n, elm_q, elm_n;
  logic             fall, rise;

  assign fall = filt_d & ~filt;
  assign rise = ~filt_d & filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      filt       <= 1'b1;
      filt_d     <= 1'b1;
      gcnt       <= '0;
      state      <= ST_IDLE;
      cnt        <= '0;
      break_hold <= '0;
      break_w_q  <= '0;
      mab_w_q    <= '0;
      fs_q       <= 1'b0;
      elb_q      <= 1'b0;
      esm_q      <= 1'b0;
      elm_q      <= 1'b0;
    end else begin
      sync1  <= bus.signal_in;
      sync2  <= sync1;
      filt_d <= filt;
      // Filter keeps running while disabled so re-enable never sees a stale level.
      if (sync2 != filt) begin
        if (gcnt == G_LAST) begin
          filt <= sync2;
          gcnt <= '0;
        end else begin
          gcnt <= gcnt + GW'(1);
        end
      end else begin
        gcnt <= '0;
      end
      state      <= state_n;
      cnt        <= cnt_n;
      break_hold <= break_hold_n;
      break_w_q  <= break_w_n;
      mab_w_q    <= mab_w_n;
      fs_q       <= fs_n;
      elb_q      <= elb_n;
      esm_q      <= esm_n;
      elm_q      <= elm_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    break_hold_n = break_hold;
    break_w_n    = break_w_q;
    mab_w_n      = mab_w_q;
    fs_n         = 1'b0;
    elb_n        = 1'b0;
    esm_n        = 1'b0;
    elm_n        = 1'b0;
    if (!bus.enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n = '0;
          if (fall) begin
            state_n = ST_BREAK;
            cnt_n   = CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (cnt >= BRK_SAT) begin
            elb_n   = 1'b1;
            state_n = ST_STUCK;
            cnt_n   = '0;
          end else if (rise) begin
            if (cnt < MIN_BREAK_CYC) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              state_n      = ST_MAB;
              cnt_n        = CNT_W'(1);
              break_hold_n = cnt;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_MAB: begin
          if (cnt >= MAB_SAT) begin
            elm_n   = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (fall) begin
            // The falling edge ending a MAB also starts the next low period.
            if (cnt < MIN_MAB_CYC) begin
              esm_n = 1'b1;
            end else begin
              fs_n      = 1'b1;
              break_w_n = break_hold;
              mab_w_n   = cnt;
            end
            state_n = ST_BREAK;
            cnt_n   = CNT_W'(1);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_STUCK: begin
          cnt_n = '0;
          if (rise) state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign bus.frame_start    = fs_q;
  assign bus.break_width    = break_w_q;
  assign bus.mab_width      = mab_w_q;
  assign bus.err_long_break = elb_q;
  assign bus.err_short_mab  = esm_q;
  assign bus.err_long_mab   = elm_q;
  assign bus.line_stuck     = (state == ST_STUCK);
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_dmx_break_mab_validator.sv
// Self-checking bench for dmx_break_mab_validator at 20 MHz with 1 ms max windows
// (MAX_BREAK_CYC = MAX_MAB_CYC = 20000) to keep stuck/long-MAB runs short.
module tb_dmx_break_mab_validator;
  localparam int CNT_W  = 32;
  localparam int EW     = 3 + 2 * CNT_W;
  localparam int MAXCYC = 20000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_e;
  logic [EW-1:0] exp_e;
  logic [3:0]    fired;

  dmx_break_mab_validator_if #(.CNT_W(CNT_W)) bus ();

  dmx_break_mab_validator #(
    .CLK_FREQ     (20_000_000),
    .MIN_BREAK_US (88),
    .MAX_BREAK_MS (1),
    .MIN_MAB_US   (8),
    .MAX_MAB_MS   (1),
    .GLITCH_CYCLES(4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run not finished, got timeout, want finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // scoreboard: every pulse from the DUT pops one expected event
  always @(negedge clk) begin
    if (rst_n) begin
      fired = {bus.err_long_mab, bus.err_short_mab, bus.err_long_break, bus.frame_start};
      for (int c = 0; c < 4; c++) begin
        if (fired[c]) begin
          obs_e = {3'(c + 1), (c == 0) ? bus.break_width : '0, (c == 0) ? bus.mab_width : '0};
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event code=%0d bw=%0d mw=%0d, want none",
                     c + 1, obs_e[2*CNT_W-1:CNT_W], obs_e[CNT_W-1:0]);
          end else begin
            exp_e = exp_q.pop_front();
            if (obs_e !== exp_e) begin
              n_fail++;
              $display("FAIL sb_event: got code=%0d bw=%0d mw=%0d, want code=%0d bw=%0d mw=%0d",
                       obs_e[EW-1:2*CNT_W], obs_e[2*CNT_W-1:CNT_W], obs_e[CNT_W-1:0],
                       exp_e[EW-1:2*CNT_W], exp_e[2*CNT_W-1:CNT_W], exp_e[CNT_W-1:0]);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic lvl, input int n);
    bus.signal_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input int bw, input int mw);
    exp_q.push_back({3'd1, CNT_W'(bw), CNT_W'(mw)});
  endtask

  task automatic push_err(input int code);
    exp_q.push_back({3'(code), CNT_W'(0), CNT_W'(0)});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.signal_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.frame_start, bus.err_long_break, bus.err_short_mab, bus.err_long_mab, bus.line_stuck} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b, want 00000",
               {bus.frame_start, bus.err_long_break, bus.err_short_mab, bus.err_long_mab, bus.line_stuck});
    end
    n_cmp++;
    if (bus.break_width !== '0 || bus.mab_width !== '0 || bus.state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_widths: got bw=%0d mw=%0d st=%0d, want 0 0 0",
               bus.break_width, bus.mab_width, bus.state_dbg);
    end
    rst_n = 1'b1;
    drive(1'b1, 20);
  endtask

  task automatic test_basic_frame;
    push_frame(2000, 240);
    drive(1'b0, 2000);
    drive(1'b1, 240);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (bus.break_width !== 32'd2000 || bus.mab_width !== 32'd240) begin
      n_fail++;
      $display("FAIL basic_widths: got bw=%0d mw=%0d, want 2000 240", bus.break_width, bus.mab_width);
    end
  endtask

  task automatic test_break_boundary;
    push_frame(1760, 240);
    drive(1'b0, 1760);
    drive(1'b1, 240);
    drive(1'b0, 80);
    drive(1'b1, 40);
    drive(1'b0, 1759);
    drive(1'b1, 240);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL brk_bound_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (bus.break_width !== 32'd1760 || bus.mab_width !== 32'd240) begin
      n_fail++;
      $display("FAIL brk_bound_widths: got bw=%0d mw=%0d, want 1760 240", bus.break_width, bus.mab_width);
    end
  endtask

  task automatic test_mab_errors;
    push_err(3);
    push_frame(2000, 160);
    drive(1'b0, 2000);
    drive(1'b1, 159);
    drive(1'b0, 2000);
    drive(1'b1, 160);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mab_err_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch;
    int spike;
    for (int k = 0; k < 2; k++) begin
      spike = 3 + k;
      if (spike == 3) push_frame(2000, 240);
      drive(1'b0, 1000);
      drive(1'b1, spike);
      drive(1'b0, 1000 - spike);
      drive(1'b1, 240);
      drive(1'b0, 80);
      drive(1'b1, 40);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (bus.break_width !== 32'd2000 || bus.mab_width !== 32'd240) begin
      n_fail++;
      $display("FAIL glitch_widths: got bw=%0d mw=%0d, want 2000 240", bus.break_width, bus.mab_width);
    end
  endtask

  task automatic test_stuck_low;
    push_err(2);
    // raw low reaches the FSM 6 edges later; error register follows cnt==MAX+1
    drive(1'b0, MAXCYC + 7);
    n_cmp++;
    if (bus.err_long_break !== 1'b0 || bus.line_stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_early: got err=%b stuck=%b, want 0 0", bus.err_long_break, bus.line_stuck);
    end
    drive(1'b0, 1);
    n_cmp++;
    if (bus.err_long_break !== 1'b1 || bus.line_stuck !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_fire: got err=%b stuck=%b, want 1 1", bus.err_long_break, bus.line_stuck);
    end
    drive(1'b0, 1);
    n_cmp++;
    if (bus.err_long_break !== 1'b0 || bus.line_stuck !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_hold: got err=%b stuck=%b, want 0 1", bus.err_long_break, bus.line_stuck);
    end
    drive(1'b0, 100);
    drive(1'b1, 20);
    n_cmp++;
    if (bus.line_stuck !== 1'b0 || bus.state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL stuck_release: got stuck=%b st=%0d, want 0 0", bus.line_stuck, bus.state_dbg);
    end
    drive(1'b1, 200);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stuck_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_mab;
    push_err(4);
    drive(1'b0, 2000);
    drive(1'b1, MAXCYC + 50);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_mab_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable;
    drive(1'b0, 2000);
    drive(1'b1, 100);
    n_cmp++;
    if (bus.state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL en_in_mab: got st=%0d, want 2", bus.state_dbg);
    end
    bus.enable = 1'b0;
    drive(1'b1, 1);
    n_cmp++;
    if (bus.state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL en_forced_idle: got st=%0d, want 0", bus.state_dbg);
    end
    drive(1'b1, 100);
    drive(1'b0, 80);
    drive(1'b1, 40);
    drive(1'b0, 2000);
    bus.enable = 1'b1;
    drive(1'b0, 50);
    drive(1'b1, 240);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL en_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (bus.break_width !== 32'd2000 || bus.mab_width !== 32'd240) begin
      n_fail++;
      $display("FAIL en_widths_held: got bw=%0d mw=%0d, want 2000 240", bus.break_width, bus.mab_width);
    end
  endtask

  task automatic test_reset_mid_break;
    drive(1'b0, 1000);
    rst_n = 1'b0;
    drive(1'b0, 1);
    n_cmp++;
    if (bus.break_width !== '0 || bus.mab_width !== '0 || bus.state_dbg !== 2'd0 ||
        {bus.frame_start, bus.err_long_break, bus.err_short_mab, bus.err_long_mab, bus.line_stuck} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_break: got bw=%0d mw=%0d st=%0d, want all zero",
               bus.break_width, bus.mab_width, bus.state_dbg);
    end
    rst_n = 1'b1;
    drive(1'b0, 1000);
    drive(1'b1, 240);
    drive(1'b0, 80);
    drive(1'b1, 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pending: got %0d events left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // sequence and final report
  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.signal_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_break_boundary();
    test_mab_errors();
    test_glitch();
    test_stuck_low();
    test_long_mab();
    test_enable();
    test_reset_mid_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
